// File: rtl/i_mem_arb.sv
// rtl/i_mem_arb.sv - instruction memory arbiter between fetch and loader with read-latency tracking
module i_mem_arb #(
    parameter int DATA_WIDTH = 128,
    parameter int ADRS_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  f_req_valid,
    input  logic [ADRS_WIDTH-1:0] f_req_adrs,
    output logic                  f_req_ready,
    output logic                  f_rsp_valid,
    output logic [DATA_WIDTH-1:0] f_rsp_data,
    input  logic                  f_flush,
    input  logic                  l_req_valid,
    input  logic                  l_req_wr,
    input  logic [ADRS_WIDTH-1:0] l_req_adrs,
    input  logic [DATA_WIDTH-1:0] l_req_data,
    input  logic                  l_lock,
    output logic                  l_req_ready,
    output logic                  l_rsp_valid,
    output logic [DATA_WIDTH-1:0] l_rsp_data,
    output logic [ADRS_WIDTH-1:0] mem_address,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [0:0] RR     = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]            state;
    logic                  last_l;   // 1 = loader was granted most recently
    logic                  up;       // first clock edge after reset has been seen
    logic [RD_LATENCY-1:0] pv;       // pipeline valid
    logic [RD_LATENCY-1:0] po;       // pipeline owner, 1 = loader
    logic [RD_LATENCY-1:0] pw;       // pipeline entry is a write ack
    logic [ADRS_WIDTH-1:0] adrs_q;
    logic                  grant_f;
    logic                  grant_l;
    logic                  xfer;

    // Pick at most one requester: loader-only while locked, otherwise round robin on ties
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (reset_n && up) begin
            if (state == LOCKED) begin
                grant_l = l_req_valid;
            end else if (f_req_valid && l_req_valid) begin
                grant_l = ~last_l;
                grant_f = last_l;
            end else begin
                grant_f = f_req_valid;
                grant_l = l_req_valid;
            end
        end
    end

    assign xfer        = grant_f | grant_l;
    assign f_req_ready = grant_f;
    assign l_req_ready = grant_l;
    assign mem_wren    = grant_l & l_req_wr;
    assign mem_data    = grant_l ? l_req_data : '0;
    assign mem_address = grant_f ? f_req_adrs : (grant_l ? l_req_adrs : adrs_q);

    // A flush also hides a fetch response that is due in the flush cycle itself
    assign f_rsp_valid = pv[RD_LATENCY-1] & ~po[RD_LATENCY-1] & ~f_flush;
    assign l_rsp_valid = pv[RD_LATENCY-1] & po[RD_LATENCY-1];
    assign f_rsp_data  = f_rsp_valid ? mem_q : '0;
    assign l_rsp_data  = (l_rsp_valid && !pw[RD_LATENCY-1]) ? mem_q : '0;

    // Hold grants off until the first edge after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) up <= 1'b0;
        else          up <= 1'b1;
    end

    // Arbitration state: lock entry on a locked loader transfer, exit when lock is seen low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RR;
            last_l <= 1'b0;
        end else if (state == RR) begin
            if (xfer)              last_l <= grant_l;
            if (grant_l && l_lock) state  <= LOCKED;
        end else begin
            if (!l_lock) begin
                state  <= RR;
                last_l <= 1'b1;
            end else if (xfer) begin
                last_l <= 1'b1;
            end
        end
    end

    // Address seen by i_mem is held between transfers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  adrs_q <= '0;
        else if (xfer) adrs_q <= mem_address;
    end

    // Response tracking pipeline; flush drops in-flight fetch entries but not the new one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            po <= '0;
            pw <= '0;
        end else begin
            pv[0] <= xfer;
            po[0] <= grant_l;
            pw[0] <= grant_l & l_req_wr;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pv[k] <= pv[k-1] & ~(f_flush & ~po[k-1]);
                po[k] <= po[k-1];
                pw[k] <= pw[k-1];
            end
        end
    end

endmodule

// File: tb/tb_i_mem_arb.sv
// tb/tb_i_mem_arb.sv - self-checking bench for i_mem_arb against a behavioural reference model
module tb_i_mem_arb;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RL = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req_valid = 1'b0;
    logic [AW-1:0] f_req_adrs = '0;
    logic          f_req_ready;
    logic          f_rsp_valid;
    logic [DW-1:0] f_rsp_data;
    logic          f_flush = 1'b0;
    logic          l_req_valid = 1'b0;
    logic          l_req_wr = 1'b0;
    logic [AW-1:0] l_req_adrs = '0;
    logic [DW-1:0] l_req_data = '0;
    logic          l_lock = 1'b0;
    logic          l_req_ready;
    logic          l_rsp_valid;
    logic [DW-1:0] l_rsp_data;
    logic [AW-1:0] mem_address;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;

    i_mem_arb #(.DATA_WIDTH(DW), .ADRS_WIDTH(AW), .RD_LATENCY(RL)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_req_valid(f_req_valid), .f_req_adrs(f_req_adrs), .f_req_ready(f_req_ready),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_flush(f_flush),
        .l_req_valid(l_req_valid), .l_req_wr(l_req_wr), .l_req_adrs(l_req_adrs),
        .l_req_data(l_req_data), .l_lock(l_lock), .l_req_ready(l_req_ready),
        .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // i_mem stand-in: write on the edge, registered read with RL clocks of latency
    logic [DW-1:0] mem [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    logic [DW-1:0] qp  [RL];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address[3:0]] <= mem_data;
        for (int k = RL - 1; k > 0; k--) qp[k] <= qp[k-1];
        qp[0] <= mem[mem_address[3:0]];
    end
    assign mem_q = qp[RL-1];

    // Reference model
    typedef struct { int due; bit ld; logic [DW-1:0] data; } rsp_t;
    rsp_t          q[$];
    logic [DW-1:0] ref_mem [16];
    bit            locked;
    bit            last_l;
    logic [AW-1:0] last_addr;
    int            cyc;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic step(input bit fv, input logic [AW-1:0] fa, input bit lv, input bit lwr,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld, input bit lk, input bit fl);
        bit            gf, gl, ef, el;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        rsp_t          nq[$];
        f_req_valid = fv; f_req_adrs = fa; l_req_valid = lv; l_req_wr = lwr;
        l_req_adrs = la; l_req_data = ld; l_lock = lk; f_flush = fl;
        @(negedge clock);
        gf = 0; gl = 0;
        if (locked)        gl = lv;
        else if (fv && lv) begin gl = !last_l; gf = last_l; end
        else               begin gf = fv; gl = lv; end
        if (fl) begin
            foreach (q[i]) if (q[i].ld) nq.push_back(q[i]);
            q = nq;
        end
        ef = 0; el = 0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].ld) el = 1; else ef = 1;
            ed = q[0].data;
            void'(q.pop_front());
        end
        ea = gf ? fa : (gl ? la : last_addr);
        chk("f_req_ready", f_req_ready, gf);
        chk("l_req_ready", l_req_ready, gl);
        chk("mem_wren", mem_wren, gl && lwr);
        chk("mem_address", mem_address, ea);
        if (gl && lwr) chk("mem_data", mem_data, ld);
        chk("f_rsp_valid", f_rsp_valid, ef);
        chk("l_rsp_valid", l_rsp_valid, el);
        if (ef) chk("f_rsp_data", f_rsp_data, ed);
        if (el) chk("l_rsp_data", l_rsp_data, ed);
        if (gf || gl) begin
            q.push_back('{cyc + RL, gl, (gl && lwr) ? '0 : ref_mem[ea[3:0]]});
            if (gl && lwr) ref_mem[ea[3:0]] = ld;
            last_l    = gl;
            last_addr = ea;
        end
        if (locked) begin
            if (!lk) begin locked = 0; last_l = 1; end
        end else if (gl && lk) begin
            locked = 1;
        end
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold reset with requests pending, check every output is zero, then release
    task automatic reset_phase();
        reset_n = 1'b0;
        f_req_valid = 1; l_req_valid = 1; l_req_wr = 1; f_req_adrs = 8'h5; l_req_adrs = 8'h6;
        @(negedge clock);
        chk("rst f_req_ready", f_req_ready, 0);
        chk("rst l_req_ready", l_req_ready, 0);
        chk("rst mem_wren", mem_wren, 0);
        chk("rst mem_address", mem_address, 0);
        chk("rst f_rsp_valid", f_rsp_valid, 0);
        chk("rst l_rsp_valid", l_rsp_valid, 0);
        chk("rst f_rsp_data", f_rsp_data, 0);
        chk("rst l_rsp_data", l_rsp_data, 0);
        advance();
        f_req_valid = 0; l_req_valid = 0; l_req_wr = 0; f_req_adrs = '0; l_req_adrs = '0;
        l_lock = 0; f_flush = 0;
        reset_n = 1'b1;
        q.delete();
        locked = 0; last_l = 0; last_addr = '0;
        advance();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = i;
        reset_phase();
        // Contention from reset: L, F, L, F
        for (int i = 0; i < 4; i++) step(1, 8'(i), 1, 0, 8'(i + 8), 0, 0, 0);
        idle(RL + 1);
        // Single fetch of address 1
        step(1, 8'h1, 0, 0, 0, 0, 0, 0);
        idle(RL + 1);
        // Write then read back
        step(0, 0, 1, 1, 8'h2, 32'h2, 0, 0);
        step(0, 0, 1, 0, 8'h2, 0, 0, 0);
        step(0, 0, 1, 1, 8'h3, 32'hdead_0003, 0, 0);
        step(0, 0, 1, 0, 8'h3, 0, 0, 0);
        idle(RL + 1);
        // Lock: three locked writes with fetch pending, idle cycle to unlock, then a tie
        step(1, 8'h4, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h4, 1, 1, 8'(10 + i), 32'ha0 + i, 1, 0);
        step(1, 8'h4, 0, 0, 0, 0, 0, 0);
        step(1, 8'h4, 1, 0, 8'h9, 0, 0, 0);
        idle(RL + 1);
        // Flush: reads on three cycles, flush on the third
        step(1, 8'h5, 0, 0, 0, 0, 0, 0);
        step(1, 8'h6, 0, 0, 0, 0, 0, 0);
        step(1, 8'h7, 0, 0, 0, 0, 0, 1);
        idle(RL + 1);
        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom_range(0, 1),
                 $urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        idle(RL + 1);
        // Reset with reads in flight
        step(1, 8'h1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 8'h2, 0, 0, 0);
        reset_phase();
        idle(RL + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i_mem_arb.md
I_MEM_ARB -- requirements
Module: i_mem_arb

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 128, which sets the instruction line width.
REQ-002 The module SHALL have parameter ADRS_WIDTH, default 32, which sets the line address width.
REQ-003 The module SHALL have parameter RD_LATENCY, default 1, legal range 1..4, giving the i_mem read latency in clocks from address to q.
REQ-004 Port clock, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port f_req_valid, input, 1: fetch read request.
REQ-007 Port f_req_adrs, input, ADRS_WIDTH: fetch line address.
REQ-008 Port f_req_ready, output, 1: fetch request accepted this cycle.
REQ-009 Port f_rsp_valid, output, 1: fetch read data valid.
REQ-010 Port f_rsp_data, output, DATA_WIDTH: fetch read data.
REQ-011 Port f_flush, input, 1: discard all outstanding fetch responses.
REQ-012 Port l_req_valid, input, 1: loader request.
REQ-013 Port l_req_wr, input, 1: loader request type, 1 = write, 0 = read.
REQ-014 Port l_req_adrs, input, ADRS_WIDTH: loader address.
REQ-015 Port l_req_data, input, DATA_WIDTH: loader write data.
REQ-016 Port l_lock, input, 1: loader burst lock.
REQ-017 Port l_req_ready, output, 1: loader request accepted this cycle.
REQ-018 Port l_rsp_valid, output, 1: loader read data valid, or write ack.
REQ-019 Port l_rsp_data, output, DATA_WIDTH: loader read data; all zeros on a write ack.
REQ-020 Ports mem_address (ADRS_WIDTH), mem_wren (1) and mem_data (DATA_WIDTH) SHALL be outputs to i_mem; mem_q (DATA_WIDTH) SHALL be an input from i_mem.

Function
REQ-021 A request SHALL transfer when valid and ready are both high in the same cycle; at most one request SHALL transfer per cycle.
REQ-022 mem_address, mem_wren and mem_data SHALL be driven combinationally from the granted request in its transfer cycle.
REQ-023 When no request transfers, mem_wren SHALL be 0 and mem_address SHALL hold its last driven value.
REQ-024 FSM states SHALL be RR and LOCKED; reset state is RR.
REQ-025 In RR, with exactly one requester valid, that requester SHALL be granted.
REQ-026 In RR, with both requesters valid, the requester not granted most recently SHALL be granted; the last-grant flag SHALL reset to fetch, so the loader wins the first tie.
REQ-027 RR SHALL go to LOCKED when a loader transfer occurs with l_lock high.
REQ-028 In LOCKED, f_req_ready SHALL be 0, and the loader SHALL be granted whenever l_req_valid is high.
REQ-029 LOCKED SHALL return to RR in the first cycle l_lock is sampled low; the loader SHALL then be last-grant, giving fetch priority on the next tie.
REQ-030 Every accepted read SHALL be tracked in a RD_LATENCY-deep shift pipeline of {valid, owner}.
REQ-031 The matching rsp_valid SHALL assert exactly RD_LATENCY cycles after acceptance, with rsp_data equal to mem_q.
REQ-032 Reads SHALL be fully pipelined, one per cycle, with no bubbles.
REQ-033 A loader write SHALL update memory in its transfer cycle.
REQ-034 A loader write SHALL produce l_rsp_valid RD_LATENCY cycles later with l_rsp_data = 0, keeping responses in request order.
REQ-035 Responses SHALL have no backpressure; requesters always accept them.
REQ-036 f_flush high SHALL clear the valid bit of every fetch-owned pipeline entry in the same cycle; loader entries SHALL be unaffected.
REQ-037 A fetch request transferring in the same cycle as f_flush SHALL be accepted and SHALL still return its response.
REQ-038 A write followed by a read to the same address in the next cycle SHALL return the new data; the block adds no forwarding and relies on i_mem write-then-read ordering.

Reset
REQ-039 While reset_n is low, the FSM SHALL be RR, the last-grant flag SHALL be fetch, and all pipeline valid bits SHALL be 0.
REQ-040 While reset_n is low, f_rsp_valid, l_rsp_valid, f_req_ready, l_req_ready and mem_wren SHALL be 0, and mem_address and both rsp_data outputs SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL drop all in-flight responses, and no response for them SHALL appear after reset_n rises.
REQ-042 Ready outputs SHALL be allowed high from the first clock edge after reset_n rises.

Verification
REQ-043 Single fetch: fetch read of adrs 0x1 with memory[0x1] = 0x1, RD_LATENCY = 1 -> f_rsp_valid high 1 cycle later with f_rsp_data = 0x1.
REQ-044 Write then read: loader writes 0x2 to adrs 0x2, then reads adrs 0x2 -> write ack with l_rsp_data = 0, then a read response of 0x2.
REQ-045 Contention: both requesters valid for 4 cycles from reset -> grant order is L, F, L, F, and 4 responses return in that order.
REQ-046 Lock: loader locks and issues 3 writes while fetch is valid throughout -> f_req_ready stays 0 for those 3 cycles; fetch is granted first on the tie after l_lock drops.
REQ-047 Flush: RD_LATENCY = 3, fetch reads issued on cycles 0, 1, 2 and f_flush on cycle 2 -> only the cycle-2 response appears, on cycle 5.
REQ-048 Reset: reset_n asserted with 2 reads in flight -> no rsp_valid appears after reset_n rises, and all outputs read 0 during reset.
